// File: rtl/bridge_packet_fifo.sv
// Packet-aware FIFO with commit/rollback on both the write and the read side.
// Optional feature macro BRIDGE_FIFO_PKT_COUNT_EN adds the pkt_count output.
module bridge_packet_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_BITS  = 9
) (
  input  logic                  clk,
  input  logic                  n_rst,
  input  logic                  clear,
  input  logic                  write_start,
  input  logic                  write_enable,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_end,
  input  logic                  write_error,
  input  logic                  read_start,
  input  logic                  read_enable,
  input  logic                  read_end,
  input  logic                  read_error,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  output logic                  fifo_empty,
  output logic                  fifo_full,
  output logic [ADDR_BITS:0]    rd_avail,
  output logic [ADDR_BITS:0]    wr_free,
  output logic                  overflow,
  output logic                  underflow
`ifdef BRIDGE_FIFO_PKT_COUNT_EN
  ,
  output logic [ADDR_BITS:0]    pkt_count
`endif
);

  localparam int DEPTH = 2**ADDR_BITS;
  typedef logic [ADDR_BITS:0] ptr_t;
  localparam ptr_t DEPTH_P = {1'b1, {ADDR_BITS{1'b0}}};
  localparam ptr_t ZERO_P  = {(ADDR_BITS+1){1'b0}};

  function automatic ptr_t ptr_add(input ptr_t p, input logic inc);
    return p + {{ADDR_BITS{1'b0}}, inc};
  endfunction

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  ptr_t wr_ptr_q, wr_ptr_d, wr_commit_q, wr_commit_d, wr_mark_q, wr_mark_d;
  ptr_t rd_ptr_q, rd_ptr_d, rd_commit_q, rd_commit_d, rd_mark_q, rd_mark_d;
  ptr_t rd_avail_q, rd_avail_d, wr_free_q, wr_free_d;
  logic                  empty_q, empty_d, full_q, full_d;
  logic                  overflow_q, overflow_d, underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  push_s, pop_s;
  logic [ADDR_BITS-1:0]  wr_addr_s;

  // Write side: push acceptance and staging/commit/rollback of the open packet.
  always_comb begin
    push_s      = write_enable & ~write_error & ~full_q;
    wr_ptr_d    = wr_ptr_q;
    wr_commit_d = wr_commit_q;
    wr_mark_d   = wr_mark_q;
    wr_addr_s   = wr_ptr_q[ADDR_BITS-1:0];
    if (write_error) begin
      wr_ptr_d = wr_mark_q;
    end else if (write_end) begin
      wr_ptr_d    = ptr_add(wr_ptr_q, push_s);
      wr_commit_d = wr_ptr_d;
      wr_mark_d   = wr_ptr_d;
    end else if (write_start) begin
      // Any uncommitted words are dropped; the new packet restarts at the mark.
      wr_addr_s = wr_mark_q[ADDR_BITS-1:0];
      wr_ptr_d  = ptr_add(wr_mark_q, push_s);
    end else begin
      wr_ptr_d = ptr_add(wr_ptr_q, push_s);
    end
  end

  // Read side: pop acceptance, rewind point and consumption commit.
  always_comb begin
    pop_s       = read_enable & ~read_error & ~empty_q;
    rd_ptr_d    = rd_ptr_q;
    rd_commit_d = rd_commit_q;
    rd_mark_d   = rd_mark_q;
    if (read_error) begin
      rd_ptr_d = rd_mark_q;
    end else if (read_end) begin
      rd_ptr_d    = ptr_add(rd_ptr_q, pop_s);
      rd_commit_d = rd_ptr_d;
      rd_mark_d   = rd_ptr_d;
    end else if (read_start) begin
      rd_ptr_d    = ptr_add(rd_ptr_q, pop_s);
      rd_commit_d = rd_ptr_q;
      rd_mark_d   = rd_ptr_q;
    end else begin
      rd_ptr_d = ptr_add(rd_ptr_q, pop_s);
    end
  end

  // Status and pop data are derived from next-state pointers so they register alongside them.
  always_comb begin
    rd_avail_d  = wr_commit_d - rd_ptr_d;
    wr_free_d   = DEPTH_P - (wr_ptr_d - rd_commit_d);
    empty_d     = (rd_avail_d == ZERO_P);
    full_d      = (wr_free_d == ZERO_P);
    overflow_d  = overflow_q | (write_enable & ~write_error & full_q);
    underflow_d = underflow_q | (read_enable & ~read_error & empty_q);
    read_valid_d = pop_s;
    if (pop_s) begin
      read_data_d = mem_q[rd_ptr_q[ADDR_BITS-1:0]];
    end else begin
      read_data_d = read_data_q;
    end
  end

  // State registers; reset and clear flush everything except the storage array.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      wr_ptr_q     <= ZERO_P;
      wr_commit_q  <= ZERO_P;
      wr_mark_q    <= ZERO_P;
      rd_ptr_q     <= ZERO_P;
      rd_commit_q  <= ZERO_P;
      rd_mark_q    <= ZERO_P;
      rd_avail_q   <= ZERO_P;
      wr_free_q    <= DEPTH_P;
      empty_q      <= 1'b1;
      full_q       <= 1'b0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      read_data_q  <= {DATA_WIDTH{1'b0}};
      read_valid_q <= 1'b0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      wr_mark_q    <= wr_mark_d;
      rd_ptr_q     <= rd_ptr_d;
      rd_commit_q  <= rd_commit_d;
      rd_mark_q    <= rd_mark_d;
      rd_avail_q   <= rd_avail_d;
      wr_free_q    <= wr_free_d;
      empty_q      <= empty_d;
      full_q       <= full_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_addr_s] <= write_data;
    end
  end

  assign read_data  = read_data_q;
  assign read_valid = read_valid_q;
  assign fifo_empty = empty_q;
  assign fifo_full  = full_q;
  assign rd_avail   = rd_avail_q;
  assign wr_free    = wr_free_q;
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

`ifdef BRIDGE_FIFO_PKT_COUNT_EN
  ptr_t pkt_q, pkt_d;
  logic pkt_inc_s, pkt_dec_s;

  // Committed-packet counter, saturating at 0 and DEPTH.
  always_comb begin
    pkt_inc_s = write_end & ~write_error;
    pkt_dec_s = read_end & ~read_error;
    pkt_d     = pkt_q;
    case ({pkt_inc_s, pkt_dec_s})
      2'b10: begin
        if (pkt_q != DEPTH_P) begin
          pkt_d = ptr_add(pkt_q, 1'b1);
        end else begin
          pkt_d = pkt_q;
        end
      end
      2'b01: begin
        if (pkt_q != ZERO_P) begin
          pkt_d = pkt_q - {{ADDR_BITS{1'b0}}, 1'b1};
        end else begin
          pkt_d = pkt_q;
        end
      end
      default: pkt_d = pkt_q;
    endcase
  end

  // Packet counter register.
  always_ff @(posedge clk) begin
    if (!n_rst || clear) begin
      pkt_q <= ZERO_P;
    end else begin
      pkt_q <= pkt_d;
    end
  end

  assign pkt_count = pkt_q;
`endif

endmodule

// File: tb/tb_bridge_packet_fifo.sv
// Directed testbench for bridge_packet_fifo (DATA_WIDTH=8, ADDR_BITS=4) with a pop-data scoreboard.
module tb_bridge_packet_fifo;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0, clear = 1'b0;
  logic       write_start = 1'b0, write_enable = 1'b0, write_end = 1'b0, write_error = 1'b0;
  logic [7:0] write_data = 8'h00;
  logic       read_start = 1'b0, read_enable = 1'b0, read_end = 1'b0, read_error = 1'b0;
  logic [7:0] read_data;
  logic       read_valid, fifo_empty, fifo_full, overflow, underflow;
  logic [4:0] rd_avail, wr_free;
`ifdef BRIDGE_FIFO_PKT_COUNT_EN
  logic [4:0] pkt_count;
`endif

  int total = 0;
  int bad   = 0;

  // Reference model: absolute word positions plus a data image indexed by them.
  logic [7:0] dmem [0:1023];
  int         c_w = 0, w_live = 0, r_live = 0, r_com = 0;
  logic       m_ovf = 1'b0, m_unf = 1'b0;
  logic [7:0] m_last = 8'h00;
  logic [7:0] exp_q [$];

  int   p_idx, c_idx, cycles;
  logic t_ws, t_we, t_wend, t_re;

  bridge_packet_fifo #(.DATA_WIDTH(8), .ADDR_BITS(4)) dut (
    .clk(clk), .n_rst(n_rst), .clear(clear),
    .write_start(write_start), .write_enable(write_enable), .write_data(write_data),
    .write_end(write_end), .write_error(write_error),
    .read_start(read_start), .read_enable(read_enable), .read_end(read_end),
    .read_error(read_error),
    .read_data(read_data), .read_valid(read_valid),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .rd_avail(rd_avail), .wr_free(wr_free),
    .overflow(overflow), .underflow(underflow)
`ifdef BRIDGE_FIFO_PKT_COUNT_EN
    , .pkt_count(pkt_count)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One clock cycle: drive, advance the model, then check the DUT one step later.
  task automatic cyc(input logic ws, input logic we, input logic [7:0] wd, input logic wend,
                     input logic werr, input logic rs, input logic re, input logic rend,
                     input logic rerr);
    logic push, pop;
    write_start = ws; write_enable = we; write_data = wd; write_end = wend; write_error = werr;
    read_start = rs; read_enable = re; read_end = rend; read_error = rerr;
    push = 1'b0;
    pop  = 1'b0;
    if (!n_rst || clear) begin
      c_w = 0; w_live = 0; r_live = 0; r_com = 0;
      m_ovf = 1'b0; m_unf = 1'b0; m_last = 8'h00;
      exp_q.delete();
    end else begin
      push = we && !werr && ((16 - (w_live - r_com)) != 0);
      pop  = re && !rerr && ((c_w - r_live) != 0);
      if (we && !werr && !push) m_ovf = 1'b1;
      if (re && !rerr && !pop) m_unf = 1'b1;
      if (werr) begin
        w_live = c_w;
      end else if (wend) begin
        if (push) begin dmem[w_live] = wd; w_live++; end
        c_w = w_live;
      end else if (ws) begin
        w_live = c_w;
        if (push) begin dmem[w_live] = wd; w_live++; end
      end else if (push) begin
        dmem[w_live] = wd; w_live++;
      end
      if (rerr) begin
        r_live = r_com;
      end else if (rend) begin
        if (pop) begin exp_q.push_back(dmem[r_live]); r_live++; end
        r_com = r_live;
      end else if (rs) begin
        r_com = r_live;
        if (pop) begin exp_q.push_back(dmem[r_live]); r_live++; end
      end else if (pop) begin
        exp_q.push_back(dmem[r_live]); r_live++;
      end
    end
    @(posedge clk);
    #1;
    chk("read_valid", {31'd0, read_valid}, {31'd0, pop});
    if (read_valid === 1'b1 && exp_q.size() > 0) m_last = exp_q.pop_front();
    chk("read_data", {24'd0, read_data}, {24'd0, m_last});
    chk("rd_avail", {27'd0, rd_avail}, c_w - r_live);
    chk("wr_free", {27'd0, wr_free}, 16 - (w_live - r_com));
    chk("fifo_empty", {31'd0, fifo_empty}, ((c_w - r_live) == 0) ? 32'd1 : 32'd0);
    chk("fifo_full", {31'd0, fifo_full}, ((16 - (w_live - r_com)) == 0) ? 32'd1 : 32'd0);
    chk("overflow", {31'd0, overflow}, {31'd0, m_ovf});
    chk("underflow", {31'd0, underflow}, {31'd0, m_unf});
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_empty"}, {31'd0, fifo_empty}, 32'd1);
    chk({tag, "_full"}, {31'd0, fifo_full}, 32'd0);
    chk({tag, "_avail"}, {27'd0, rd_avail}, 32'd0);
    chk({tag, "_free"}, {27'd0, wr_free}, 32'd16);
    chk({tag, "_rdata"}, {24'd0, read_data}, 32'd0);
    chk({tag, "_rvalid"}, {31'd0, read_valid}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, overflow}, 32'd0);
    chk({tag, "_unf"}, {31'd0, underflow}, 32'd0);
  endtask

  initial begin
    // Reset
    n_rst = 1'b0;
    idle();
    idle();
    n_rst = 1'b1;
    chk_reset_state("reset");

    // Commit path
    cyc(1'b1, 1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("commit_avail", {27'd0, rd_avail}, 32'd4);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("commit_first", {24'd0, read_data}, 32'h11);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("commit_last", {24'd0, read_data}, 32'h14);
    idle();
    chk("commit_hold", {24'd0, read_data}, 32'h14);

    // Write rollback
    cyc(1'b1, 1'b1, 8'h51, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 8'(8'h52 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h5F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rollback_avail", {27'd0, rd_avail}, 32'd0);
    chk("rollback_free", {27'd0, wr_free}, 32'd16);
    cyc(1'b1, 1'b1, 8'hA0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("rollback_a0", {24'd0, read_data}, 32'hA0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rollback_a1", {24'd0, read_data}, 32'hA1);

    // Read rewind
    cyc(1'b1, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    chk("rewind_avail", {27'd0, rd_avail}, 32'd3);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("rewind_re01", {24'd0, read_data}, 32'h01);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("rewind_re03", {24'd0, read_data}, 32'h03);
    chk("rewind_free", {27'd0, wr_free}, 32'd16);

    // Full / overflow
    cyc(1'b1, 1'b1, 8'hC0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 15; i++) cyc(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'hCF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_set", {31'd0, fifo_full}, 32'd1);
    cyc(1'b0, 1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("full_overflow", {31'd0, overflow}, 32'd1);
    chk("full_avail", {27'd0, rd_avail}, 32'd16);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i < 15; i++) cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("full_held_by_pops", {31'd0, fifo_full}, 32'd1);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("full_last", {24'd0, read_data}, 32'hCF);
    chk("full_cleared", {31'd0, fifo_full}, 32'd0);
    chk("full_free", {27'd0, wr_free}, 32'd16);

    // Wrap with concurrent push/pop, packets of 7
    p_idx = 0; c_idx = 0; cycles = 0;
    while (c_idx < 40 && cycles < 400) begin
      t_we   = (p_idx < 40) && ((16 - (w_live - r_com)) > 0);
      t_ws   = t_we && ((p_idx % 7) == 0);
      t_wend = t_we && (((p_idx % 7) == 6) || (p_idx == 39));
      t_re   = (c_w - r_live) > 0;
      cyc(t_ws, t_we, 8'(p_idx + 64), t_wend, 1'b0, 1'b0, t_re, t_re, 1'b0);
      chk("wrap_avail_max", {31'd0, (rd_avail <= 5'd16)}, 32'd1);
      if (t_we) p_idx++;
      if (t_re) c_idx++;
      cycles++;
    end
    chk("wrap_consumed", c_idx, 32'd40);
    chk("wrap_queue_drained", exp_q.size(), 32'd0);

    // Reset mid-packet
    cyc(1'b1, 1'b1, 8'h71, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 8'h72, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h73, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    n_rst = 1'b0;
    cyc(1'b0, 1'b1, 8'h74, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    n_rst = 1'b1;
    chk_reset_state("midrst");
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    chk("underflow_set", {31'd0, underflow}, 32'd1);
    chk("underflow_no_valid", {31'd0, read_valid}, 32'd0);

    // Clear mid-packet
    cyc(1'b1, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 8'h82, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    chk("clear_pre_data", {24'd0, read_data}, 32'h81);
    clear = 1'b1;
    cyc(1'b0, 1'b1, 8'h83, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    clear = 1'b0;
    chk_reset_state("clear");
    cyc(1'b1, 1'b1, 8'h91, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("after_clear_data", {24'd0, read_data}, 32'h91);
    idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bridge_packet_fifo.md
# bridge_packet_fifo

Parametrised packet-aware FIFO for the USB-to-Ethernet and Ethernet-to-USB data paths. It supports configurable data width and depth, with transactional commit and rollback on both sides. The write side stages a packet and publishes it only on commit; an error discards it. The read side can rewind to the start of the current packet for retransmission, and frees space only when the packet is committed as consumed. It replaces the fixed 8-bit/512-entry byte FIFOs between the USB endpoint logic and the Ethernet MAC.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one FIFO word
- ADDR_BITS, 9, address width; DEPTH = 2**ADDR_BITS words

Ports:
- clk  input  1  system clock, all logic on rising edge
- n_rst  input  1  synchronous active-low reset, sampled on rising edge of clk
- clear  input  1  synchronous flush of all pointers, counters and flags
- write_start  input  1  marks first cycle of a new write packet
- write_enable  input  1  push write_data
- write_data  input  DATA_WIDTH  data to push
- write_end  input  1  commit open write packet
- write_error  input  1  discard open write packet
- read_start  input  1  marks start of a read packet (saves rewind point)
- read_enable  input  1  pop one word
- read_end  input  1  commit read packet, release its space
- read_error  input  1  rewind read pointer to saved start
- read_data  output  DATA_WIDTH  registered pop data
- read_valid  output  1  read_data holds a word popped the previous cycle
- fifo_empty  output  1  no committed, unread words
- fifo_full  output  1  no free space for writing
- rd_avail  output  ADDR_BITS+1  committed unread words
- wr_free  output  ADDR_BITS+1  free word slots
- overflow  output  1  sticky: write attempted while full
- underflow  output  1  sticky: read attempted while empty

## Operation
- Pointers: six ADDR_BITS+1 wide pointers. wr_ptr and wr_commit are the live and committed write positions. rd_ptr and rd_commit are the live and committed read positions. wr_mark and rd_mark are the saved packet starts. The MSB disambiguates full from empty, and pointers wrap modulo 2*DEPTH.
- Counts:
  - rd_avail = wr_commit - rd_ptr
  - wr_free = DEPTH - (wr_ptr - rd_commit)
  - fifo_empty = (rd_avail == 0)
  - fifo_full = (wr_free == 0)
- Write side, per cycle:
  - write_error: wr_ptr <= wr_commit. A write_enable in the same cycle is discarded.
  - Else write_end: wr_commit <= wr_ptr + accepted push. The same-cycle push is included as the last word.
  - Else write_start: an uncommitted open packet is implicitly discarded first. The same-cycle push is the packet's first word.
  - A push is accepted only when fifo_full=0. A push while full is dropped and sets overflow.
- Read side, per cycle:
  - read_error: rd_ptr <= rd_commit. A read_enable in the same cycle is ignored.
  - Else read_end: rd_commit <= rd_ptr + accepted pop.
  - Else read_start: rd_commit <= rd_ptr, i.e. the rewind point.
  - A pop is accepted only when fifo_empty=0. A pop while empty is ignored, sets underflow and leaves read_valid=0.
- Simultaneous push and pop are both honoured. Committed data never becomes unreadable because of write-side activity.
- Storage: DEPTH x DATA_WIDTH register array, written at wr_ptr[ADDR_BITS-1:0].
- clear and n_rst=0 set all pointers to 0 and set read_data=0, read_valid=0, overflow=0, underflow=0. n_rst has priority over clear.

## Timing
- Reset values: fifo_empty=1, fifo_full=0, rd_avail=0, wr_free=DEPTH, read_data=0, read_valid=0, overflow=0, underflow=0.
- Pop latency: read_enable accepted in cycle N gives read_data/read_valid in cycle N+1. read_data holds its value until the next accepted pop.
- Status latency: all flags and counts are registered from pointers and reflect events of cycle N in cycle N+1.
- Commit visibility: a word pushed and committed in cycle N is poppable from cycle N+1 (rd_avail updated in N+1).
- Free-space visibility: space is freed only at read_end. Pops alone never lower fifo_full.
- Reset mid-packet: open packets on both sides are lost and the FIFO is empty in the next cycle.

## Configuration
- BRIDGE_FIFO_PKT_COUNT_EN
  - Defined: adds output pkt_count (ADDR_BITS+1 bits, reset 0).
    - Increments on each write_end.
    - Decrements on each read_end.
    - Net 0 when both occur in the same cycle.
    - Saturates at 0 and at DEPTH.
  - Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
Configuration for all scenarios: DATA_WIDTH=8, ADDR_BITS=4 (DEPTH=16).
- Commit path: write_start + push 0x11..0x14, write_end on the 0x14 push cycle -> rd_avail=4 next cycle; popping 4 words returns 0x11,0x12,0x13,0x14 each one cycle after read_enable.
- Write rollback: push 5 words, then write_error -> rd_avail stays 0, wr_free returns to 16; the next packet 0xA0,0xA1 is committed and read back correctly.
- Read rewind: commit 3 words 0x01..0x03, read_start, pop 2, read_error -> rd_avail=3; re-pop yields 0x01,0x02,0x03; read_end -> wr_free=16.
- Full/overflow: commit 16 words without read_end -> fifo_full=1; a 17th push is dropped and sets overflow=1; pop 16 + read_end -> fifo_full=0, wr_free=16.
- Wrap and simultaneous: cycle through 40 words in packets of 7 with concurrent push/pop -> data order is preserved across pointer wrap, and rd_avail never exceeds 16.
- Reset/clear mid-packet: n_rst=0 for one cycle during an open write and an active read -> all outputs return to their reset values the next cycle; a pop while empty sets underflow=1.
